hyst_bram_arbiter: RTL and testbench
====================================

# hyst_bram_arbiter

Arbiter and frame sequencer for the single-port hysteresis result BRAM. It shares one BRAM port between three requesters: the hysteresis writer, the Hough reader (rd0) and the highlight/display reader (rd1). It tracks how much of the current frame has been written, so readers never fetch a pixel before it exists. It sits between the hysteresis stage and the BRAM, upstream of the Hough and highlight paths.

## Interface
Parameters:
- WIDTH, 1280, image width in pixels
- HEIGHT, 720, image height in pixels
- IMAGE_SIZE, WIDTH*HEIGHT, pixels per frame
- ADDR_W, $clog2(IMAGE_SIZE), BRAM address width
- RD_LATENCY, 1, BRAM read latency in cycles (1..4)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- wr_req  in  1  writer request; held until wr_gnt
- wr_addr  in  ADDR_W  write address
- wr_data  in  8  hysteresis pixel
- wr_gnt  out  1  write performed this cycle
- rd0_req / rd1_req  in  1  reader request; held until granted
- rd0_addr / rd1_addr  in  ADDR_W  read address
- rd0_gnt / rd1_gnt  out  1  read issued this cycle
- rd0_valid / rd1_valid  out  1  read data valid
- rd0_data / rd1_data  out  8  read data
- bram_en, bram_we  out  1  BRAM port enable and write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_wr_data  out  8  BRAM write data
- bram_rd_data  in  8  BRAM read data, RD_LATENCY cycles after bram_en with bram_we=0
- frame_done  out  1  one-cycle pulse when a full frame has been written (drives hough_start)
- frame_ready  out  1  level: the current frame is completely written

## Operation
Frame FSM, two states:
- FILLING: entered at reset.
  - wr_count (ADDR_W+1 bits) increments on every wr_gnt.
  - When the grant that makes wr_count == IMAGE_SIZE occurs, pulse frame_done, set frame_ready, clear wr_count and go to COMPLETE.
- COMPLETE: frame_ready=1.
  - The first wr_gnt clears frame_ready, sets wr_count=1 and returns to FILLING. If IMAGE_SIZE==1, this grant also completes a frame.

Read eligibility:
- rdN is eligible iff rdN_req and (frame_ready or rdN_addr < wr_count).
- A reader whose address is not yet written waits; it is not an error.

Arbitration:
- One grant at most per cycle; grants are combinational in the request cycle.
- wr_req always wins.
- Between eligible readers, round-robin: rr_ptr toggles to the other reader after each read grant. rr_ptr resets to rd0.

BRAM drive:
- On a write grant: bram_en=1, bram_we=1, addr and data from the writer.
- On a read grant: bram_en=1, bram_we=0, bram_addr=rdN_addr.
- Otherwise all BRAM outputs are 0.

Response path:
- A tag pipeline of RD_LATENCY stages carries {valid, reader id}.
- rdN_valid=1 with rdN_data=bram_rd_data when the tag exits the pipeline.
- rdN_data holds its last value when rdN_valid is low.

Widths:
- wr_addr is not checked against the fill order.
- Addresses ≥ IMAGE_SIZE are passed to the BRAM unchanged.

## Timing
- Grant latency: 0 cycles when the requester is eligible and wins.
- Read data latency: exactly RD_LATENCY cycles from rdN_gnt to rdN_valid. Back-to-back grants give back-to-back valids.
- frame_done asserts in the cycle after the final write grant. frame_ready rises in the same cycle.
- A read of address A granted in the cycle after the write grant to A returns the new data. The single port makes a same-cycle read/write of A impossible.
- Reset (including mid-frame or mid-read):
  - All outputs go to 0 in the cycle after reset is sampled.
  - The tag pipeline is flushed, so in-flight reads produce no valid.
  - wr_count=0, FSM=FILLING, rr_ptr=rd0.

## Configuration
- HYST_ARB_WR_FAIRNESS_EN: when defined, a 4-bit starve counter per reader counts cycles it was eligible but lost to the writer.
  - At 15, that reader gets one grant ahead of the writer, then its counter clears.
- When undefined, the writer has strict priority and readers can starve during a continuous write burst.

## Structure
- Package hyst_arb_pkg contains:
  - typedef enum logic [1:0] {REQ_NONE, REQ_WR, REQ_RD0, REQ_RD1} req_id_t
  - typedef enum logic {FILLING, COMPLETE} frame_state_t
  - struct tag_t {valid, reader id}
  - STARVE_MAX=15
- Sub-module hyst_arb_tag_pipe holds the RD_LATENCY-deep tag shift register with synchronous flush.

## Test plan
- Reset, then write addresses 0..IMAGE_SIZE-1 (WIDTH=4, HEIGHT=2) with no readers: wr_gnt every cycle, frame_done pulses once on the cycle after write 7, frame_ready=1.
- wr_count=3 and rd0_addr=5: rd0_gnt=0 until the write to address 5 is granted, then rd0_gnt the next cycle; rd0_valid with the written value 1 cycle later.
- rd0 and rd1 both eligible continuously, no writer: grants alternate rd0, rd1, rd0…; each valid matches its reader's address data.
- Writer and both readers continuously active, macro undefined: readers never granted. Macro defined: each reader is granted once after 15 eligible lost cycles.
- RD_LATENCY=3, assert reset while two reads are in flight: no rdN_valid afterwards, all outputs 0, frame_ready=0.
- Frame complete, then one new write: frame_ready falls and a read of address 4 stalls until address 4 is rewritten.

Source files
------------

// File: rtl/hyst_arb_pkg.sv
// Shared types for the hysteresis BRAM arbiter: requester ids, frame FSM
// states, read-response tags and the reader round-robin helper.
package hyst_arb_pkg;

    typedef enum logic [1:0] {REQ_NONE, REQ_WR, REQ_RD0, REQ_RD1} req_id_t;

    typedef enum logic {FILLING, COMPLETE} frame_state_t;

    typedef struct packed {
        logic valid;
        logic rd_id;   // 0 = rd0 (Hough), 1 = rd1 (highlight)
    } tag_t;

    localparam int unsigned STARVE_MAX = 15;

    // Choose between two candidate readers; on a tie the reader named by
    // prefer_rd1 wins.
    function automatic req_id_t rr_pick(logic cand0, logic cand1, logic prefer_rd1);
        req_id_t pick;
        pick = REQ_NONE;
        if (cand0 && cand1) begin
            pick = prefer_rd1 ? REQ_RD1 : REQ_RD0;
        end else if (cand0) begin
            pick = REQ_RD0;
        end else if (cand1) begin
            pick = REQ_RD1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/hyst_arb_tag_pipe.sv
// Read-response tag delay line: DEPTH stages of {valid, reader id} that
// track BRAM read latency. Synchronous flush drops every in-flight tag.
module hyst_arb_tag_pipe
    import hyst_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clock,
    input  logic flush_i,
    input  logic valid_i,
    input  logic id_i,
    output logic valid_o,
    output logic id_o
);

    tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; flush clears all stages.
    always_ff @(posedge clock) begin
        if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: valid_i, rd_id: id_i};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[DEPTH-1].valid;
    assign id_o    = stage_q[DEPTH-1].rd_id;

endmodule

// File: rtl/hyst_bram_arbiter.sv
// Single-port BRAM arbiter and frame sequencer for hysteresis results.
// Writer has priority; two readers share the remaining slots round-robin and
// may only read pixels already written in the current frame.
// Optional: HYST_ARB_WR_FAIRNESS_EN lets a reader starved by the writer for
// STARVE_MAX eligible cycles take one grant ahead of the writer.
module hyst_bram_arbiter
    import hyst_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 1280,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned IMAGE_SIZE = WIDTH * HEIGHT,
    parameter int unsigned ADDR_W     = $clog2(IMAGE_SIZE),
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_valid,
    output logic [7:0]        rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [7:0]        rd1_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wr_data,
    input  logic [7:0]        bram_rd_data,
    output logic              frame_done,
    output logic              frame_ready
);

    localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W+1)'(IMAGE_SIZE);

    frame_state_t    state_q, state_d;
    logic [ADDR_W:0] wr_count_q, wr_count_d, count_next;
    logic            frame_done_q, frame_done_d;
    logic            rr_q, rr_d;          // 1: rd1 wins the next reader tie
    logic [7:0]      rd0_hold_q, rd1_hold_q;
    logic            rd0_elig, rd1_elig;
    logic            tag_valid, tag_id;
    req_id_t         gnt_id;

    assign frame_ready = (state_q == COMPLETE);
    assign frame_done  = frame_done_q;

    assign rd0_elig = rd0_req && (frame_ready || ({1'b0, rd0_addr} < wr_count_q));
    assign rd1_elig = rd1_req && (frame_ready || ({1'b0, rd1_addr} < wr_count_q));

`ifdef HYST_ARB_WR_FAIRNESS_EN
    logic [3:0] starve0_q, starve0_d, starve1_q, starve1_d;
    logic       rd0_starved, rd1_starved;

    assign rd0_starved = rd0_elig && (starve0_q == 4'(STARVE_MAX));
    assign rd1_starved = rd1_elig && (starve1_q == 4'(STARVE_MAX));

    // Count cycles each reader was eligible but lost to the writer.
    always_comb begin
        starve0_d = starve0_q;
        starve1_d = starve1_q;
        if (gnt_id == REQ_RD0) begin
            starve0_d = '0;
        end else if (rd0_elig && gnt_id == REQ_WR && starve0_q != 4'(STARVE_MAX)) begin
            starve0_d = starve0_q + 4'd1;
        end
        if (gnt_id == REQ_RD1) begin
            starve1_d = '0;
        end else if (rd1_elig && gnt_id == REQ_WR && starve1_q != 4'(STARVE_MAX)) begin
            starve1_d = starve1_q + 4'd1;
        end
    end

    // Starvation counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve0_q <= '0;
            starve1_q <= '0;
        end else begin
            starve0_q <= starve0_d;
            starve1_q <= starve1_d;
        end
    end
`endif

    // Pick at most one requester per cycle; nothing is granted during reset.
    always_comb begin
        gnt_id = REQ_NONE;
        if (!reset) begin
            if (wr_req) begin
                gnt_id = REQ_WR;
            end else begin
                gnt_id = rr_pick(rd0_elig, rd1_elig, rr_q);
            end
`ifdef HYST_ARB_WR_FAIRNESS_EN
            if (rd0_starved || rd1_starved) begin
                gnt_id = rr_pick(rd0_starved, rd1_starved, rr_q);
            end
`endif
        end
    end

    assign wr_gnt  = (gnt_id == REQ_WR);
    assign rd0_gnt = (gnt_id == REQ_RD0);
    assign rd1_gnt = (gnt_id == REQ_RD1);

    // Drive the BRAM port from the granted requester, zero when idle.
    always_comb begin
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_wr_data = '0;
        case (gnt_id)
            REQ_WR: begin
                bram_en      = 1'b1;
                bram_we      = 1'b1;
                bram_addr    = wr_addr;
                bram_wr_data = wr_data;
            end
            REQ_RD0: begin
                bram_en   = 1'b1;
                bram_addr = rd0_addr;
            end
            REQ_RD1: begin
                bram_en   = 1'b1;
                bram_addr = rd1_addr;
            end
            default: ;
        endcase
    end

    // Frame fill tracking. The first write after COMPLETE restarts the count
    // from zero, so both states share one increment-and-compare path.
    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        frame_done_d = 1'b0;
        count_next   = ((state_q == COMPLETE) ? '0 : wr_count_q) + (ADDR_W+1)'(1);
        if (wr_gnt) begin
            if (count_next == FRAME_LEN) begin
                state_d      = COMPLETE;
                wr_count_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                state_d    = FILLING;
                wr_count_d = count_next;
            end
        end
    end

    // Last-granted reader loses the next tie.
    always_comb begin
        rr_d = rr_q;
        if (gnt_id == REQ_RD0) begin
            rr_d = 1'b1;
        end else if (gnt_id == REQ_RD1) begin
            rr_d = 1'b0;
        end
    end

    // Frame, round-robin and read-data hold registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FILLING;
            wr_count_q   <= '0;
            frame_done_q <= 1'b0;
            rr_q         <= 1'b0;
            rd0_hold_q   <= '0;
            rd1_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_count_q   <= wr_count_d;
            frame_done_q <= frame_done_d;
            rr_q         <= rr_d;
            if (rd0_valid) begin
                rd0_hold_q <= bram_rd_data;
            end
            if (rd1_valid) begin
                rd1_hold_q <= bram_rd_data;
            end
        end
    end

    hyst_arb_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clock   (clock),
        .flush_i (reset),
        .valid_i (rd0_gnt || rd1_gnt),
        .id_i    (rd1_gnt),
        .valid_o (tag_valid),
        .id_o    (tag_id)
    );

    assign rd0_valid = tag_valid && !tag_id;
    assign rd1_valid = tag_valid && tag_id;
    assign rd0_data  = rd0_valid ? bram_rd_data : rd0_hold_q;
    assign rd1_data  = rd1_valid ? bram_rd_data : rd1_hold_q;

endmodule

// File: tb/tb_hyst_bram_arbiter.sv
// Self-checking bench for hyst_bram_arbiter (4x2 image, 3-cycle BRAM).
module tb_hyst_bram_arbiter;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int IS = W * H;
    localparam int AW = 3;
    localparam int L  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0, rd0_req = 1'b0, rd1_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
    logic [7:0]    rd0_data, rd1_data, bram_wr_data, bram_rd_data;
    logic          bram_en, bram_we, frame_done, frame_ready;
    logic [AW-1:0] bram_addr;

    always #5 clock = ~clock;

    hyst_bram_arbiter #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .RD_LATENCY (L)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .rd0_req      (rd0_req),
        .rd0_addr     (rd0_addr),
        .rd0_gnt      (rd0_gnt),
        .rd0_valid    (rd0_valid),
        .rd0_data     (rd0_data),
        .rd1_req      (rd1_req),
        .rd1_addr     (rd1_addr),
        .rd1_gnt      (rd1_gnt),
        .rd1_valid    (rd1_valid),
        .rd1_data     (rd1_data),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wr_data (bram_wr_data),
        .bram_rd_data (bram_rd_data),
        .frame_done   (frame_done),
        .frame_ready  (frame_ready)
    );

    // BRAM: writes land at the edge, reads return L cycles after bram_en;
    // idle slots return noise.
    logic [7:0] mem   [IS] = '{default: 8'h00};
    logic [7:0] rpipe [L]  = '{default: 8'h00};
    assign bram_rd_data = rpipe[L-1];

    always @(posedge clock) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wr_data;
        for (int i = L - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= (bram_en && !bram_we) ? mem[bram_addr] : 8'($urandom);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as an integer count, shadow image of
    // everything the writer was granted, and a queue of promised read data.
    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } pend_t;

    pend_t      pq[$];
    pend_t      pe;
    bit         m_init = 0;
    int         m_cnt = 0;
    bit         m_ready = 0, m_done = 0;
    int         m_rr = 0;
    int         m_starve[2] = '{0, 0};
    logic [7:0] m_mem[IS] = '{default: 8'h00};
    logic [7:0] m_hold[2] = '{8'h00, 8'h00};
    int         cyc = 0;
    bit         g_wr = 0;
    bit         g_rd[2] = '{0, 0};

    bit            rq[2], el[2], ev[2];
    logic [AW-1:0] ra[2];
    logic [7:0]    ed[2];
    logic [AW-1:0] e_addr;
    int            win;

    function automatic int pick(bit a, bit b, int pref);
        if (a && b) return pref;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    always @(negedge clock) begin
        rq[0] = rd0_req;  rq[1] = rd1_req;
        ra[0] = rd0_addr; ra[1] = rd1_addr;
        for (int n = 0; n < 2; n++) el[n] = rq[n] && (m_ready || int'(ra[n]) < m_cnt);
        win = -1;
        if (!reset) begin
            win = wr_req ? 2 : pick(el[0], el[1], m_rr);
`ifdef HYST_ARB_WR_FAIRNESS_EN
            if ((el[0] && m_starve[0] >= 15) || (el[1] && m_starve[1] >= 15))
                win = pick(el[0] && m_starve[0] >= 15, el[1] && m_starve[1] >= 15, m_rr);
`endif
        end
        ev = '{0, 0};
        ed = m_hold;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            ev[pq[0].id] = 1;
            ed[pq[0].id] = pq[0].data;
        end
        e_addr = (win == 2) ? wr_addr : (win >= 0) ? ra[win] : '0;

        if (m_init) begin
            chk("wr_gnt", wr_gnt, win == 2);
            chk("rd0_gnt", rd0_gnt, win == 0);
            chk("rd1_gnt", rd1_gnt, win == 1);
            chk("bram_en", bram_en, win != -1);
            chk("bram_we", bram_we, win == 2);
            chk("bram_addr", bram_addr, e_addr);
            chk("bram_wr_data", bram_wr_data, (win == 2) ? wr_data : 8'h00);
            chk("rd0_valid", rd0_valid, ev[0]);
            chk("rd1_valid", rd1_valid, ev[1]);
            chk("rd0_data", rd0_data, ed[0]);
            chk("rd1_data", rd1_data, ed[1]);
            chk("frame_done", frame_done, m_done);
            chk("frame_ready", frame_ready, m_ready);
        end

        if (reset) begin
            m_init = 1; m_cnt = 0; m_ready = 0; m_done = 0; m_rr = 0;
            m_starve = '{0, 0}; m_hold = '{8'h00, 8'h00};
            pq.delete();
        end else begin
            if (ev[0] || ev[1]) begin
                m_hold = ed;
                void'(pq.pop_front());
            end
            m_done = 0;
            if (win == 2) begin
                m_mem[wr_addr] = wr_data;
                m_cnt = (m_ready ? 0 : m_cnt) + 1;
                m_ready = 0;
                if (m_cnt == IS) begin
                    m_cnt = 0; m_ready = 1; m_done = 1;
                end
            end else if (win >= 0) begin
                pe.due = cyc + L; pe.id = win; pe.data = m_mem[ra[win]];
                pq.push_back(pe);
                m_rr = 1 - win;
            end
            for (int n = 0; n < 2; n++) begin
                if (win == n) m_starve[n] = 0;
                else if (el[n] && win == 2 && m_starve[n] < 15) m_starve[n]++;
            end
        end
        g_wr = (win == 2);
        g_rd[0] = (win == 0);
        g_rd[1] = (win == 1);
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    int prev, g, nrd, nrd0, nrd1, first_rd;

    initial begin
        // Reset
        repeat (3) tick();
        mid();
        chk("reset_frame_ready", frame_ready, 0);
        chk("reset_valids", {rd0_valid, rd1_valid}, 0);
        tick();
        reset = 0;

        // Fill one frame, no readers
        for (int a = 0; a < IS; a++) begin
            wr_req = 1; wr_addr = AW'(a); wr_data = 8'($urandom);
            mid();
            chk("fill_wr_gnt", wr_gnt, 1);
            chk("fill_done_low", frame_done, 0);
            tick();
        end
        wr_req = 0;
        mid();
        chk("fill_done_pulse", frame_done, 1);
        chk("fill_ready", frame_ready, 1);
        tick();
        mid();
        chk("fill_done_once", frame_done, 0);
        chk("fill_ready_hold", frame_ready, 1);
        tick();

        // New frame: read of address 4 stalls until it is rewritten
        wr_req = 1; wr_addr = 0; wr_data = 8'($urandom);
        rd0_req = 1; rd0_addr = 4;
        mid();
        chk("refill_wr_wins", wr_gnt, 1);
        tick();
        for (int a = 1; a < 4; a++) begin
            wr_addr = AW'(a); wr_data = 8'($urandom);
            mid();
            chk("stall_rd0_gnt", rd0_gnt, 0);
            chk("stall_ready_low", frame_ready, 0);
            tick();
        end
        wr_req = 0;
        mid();
        chk("stall_idle_rd0_gnt", rd0_gnt, 0);
        tick();
        wr_req = 1; wr_addr = 4; wr_data = 8'hA5;
        mid();
        chk("stall_during_write", rd0_gnt, 0);
        tick();
        wr_req = 0;
        mid();
        chk("stall_release_gnt", rd0_gnt, 1);
        tick();
        rd0_req = 0;
        repeat (L - 1) tick();
        mid();
        chk("stall_valid", rd0_valid, 1);
        chk("stall_data", rd0_data, 8'hA5);
        tick();
        for (int a = 5; a < IS; a++) begin
            wr_req = 1; wr_addr = AW'(a); wr_data = 8'($urandom);
            tick();
        end
        wr_req = 0;
        tick();

        // Both readers continuously eligible: strict alternation
        rd0_req = 1; rd1_req = 1;
        rd0_addr = AW'($urandom); rd1_addr = AW'($urandom);
        prev = -1;
        for (int k = 0; k < 16; k++) begin
            mid();
            g = rd0_gnt ? 0 : (rd1_gnt ? 1 : -1);
            chk("rr_grant_each_cycle", g >= 0, 1);
            if (prev >= 0) chk("rr_alternate", g != prev, 1);
            prev = g;
            tick();
            if (g_rd[0]) rd0_addr = AW'($urandom);
            if (g_rd[1]) rd1_addr = AW'($urandom);
        end
        rd0_req = 0; rd1_req = 0;
        repeat (L + 1) tick();

        // Continuous writer against both readers
        nrd0 = 0; nrd1 = 0; first_rd = -1;
        rd0_req = 1; rd1_req = 1; rd0_addr = 0; rd1_addr = 0;
        wr_req = 1;
        for (int k = 0; k < 20; k++) begin
            wr_addr = AW'(k % IS); wr_data = 8'($urandom);
            mid();
            if (rd0_gnt) nrd0++;
            if (rd1_gnt) nrd1++;
            if ((rd0_gnt || rd1_gnt) && first_rd < 0) first_rd = k;
            tick();
            if (g_wr) wr_addr = AW'((k + 1) % IS);
        end
`ifdef HYST_ARB_WR_FAIRNESS_EN
        chk("starve_rd0_grants", nrd0, 1);
        chk("starve_rd1_grants", nrd1, 1);
        chk("starve_first_grant_cycle", first_rd, 15);
`else
        chk("starve_rd0_grants", nrd0, 0);
        chk("starve_rd1_grants", nrd1, 0);
`endif
        wr_req = 0; rd0_req = 0; rd1_req = 0;
        repeat (L + 1) tick();

        // Randomized traffic, requests held until granted
        for (int k = 0; k < 400; k++) begin
            if (!wr_req || g_wr) begin
                wr_req = ($urandom_range(0, 2) == 0);
                wr_addr = AW'($urandom); wr_data = 8'($urandom);
            end
            if (!rd0_req || g_rd[0]) begin
                rd0_req = ($urandom_range(0, 1) == 0); rd0_addr = AW'($urandom);
            end
            if (!rd1_req || g_rd[1]) begin
                rd1_req = ($urandom_range(0, 1) == 0); rd1_addr = AW'($urandom);
            end
            tick();
        end
        wr_req = 0; rd0_req = 0; rd1_req = 0;
        tick();

        // Reset with two reads in flight
        for (int k = 0; k < 2 * IS && !m_ready; k++) begin
            wr_req = 1; wr_addr = AW'(k % IS); wr_data = 8'($urandom);
            tick();
        end
        wr_req = 0;
        mid();
        chk("pre_reset_ready", frame_ready, 1);
        tick();
        rd0_req = 1; rd0_addr = 2; rd1_req = 1; rd1_addr = 6;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("inflight_gnt", rd0_gnt || rd1_gnt, 1);
            tick();
        end
        rd0_req = 0; rd1_req = 0; reset = 1;
        tick();
        reset = 0;
        for (int k = 0; k < L + 2; k++) begin
            mid();
            chk("post_reset_no_valid", {rd0_valid, rd1_valid}, 0);
            chk("post_reset_ready", frame_ready, 0);
            chk("post_reset_done", frame_done, 0);
            chk("post_reset_data", {rd0_data, rd1_data}, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
